// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the round-robin transmitter arbiter.
package uart_tx_arbiter_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_FRAME_CYCLES = 160;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_START = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Rotating-priority search: first set request strictly after the last winner.
module uart_rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_last,
    output logic             o_valid,
    output logic [IDW-1:0]   o_idx
);

    logic [IDW-1:0] w_pos;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        // Offset N_REQ wraps back onto the last winner, so it has lowest priority.
        for (int i = 1; i <= N_REQ; i++) begin
            w_pos = IDW'((int'(i_last) + i) % N_REQ);
            if (!o_valid && i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one tx_top transmitter between N_REQ byte producers, one frame at a time.
//   state     | meaning
//   ARB_IDLE  | sample REQ, launch a frame for the round-robin winner
//   ARB_START | TX_START active, ACK pulse to the winner, byte on TX_DATA_IN
//   ARB_WAIT  | hold the transmitter for the remaining FRAME_CYCLES-1 cycles
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int   N_REQ        = 4,
    parameter int   DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int   FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter logic START_LEVEL  = 1'b0
) (
    input  logic                        TX_CLK,
    input  logic                        TX_RST,
    input  logic [N_REQ-1:0]            REQ,
    input  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [N_REQ-1:0]            ACK,
    output logic [DATA_WIDTH-1:0]       TX_DATA_IN,
    output logic                        TX_START,
    output logic                        BUSY,
    output logic [$clog2(N_REQ)-1:0]    GRANT_ID
);

    localparam int             IDW    = $clog2(N_REQ);
    localparam int             CW     = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0]  CNT_TC = CW'(FRAME_CYCLES - 2);

    arb_state_t              r_state;
    logic [N_REQ-1:0]        r_ack;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_tx_start;
    logic                    r_busy;
    logic [IDW-1:0]          r_grant;
    logic [IDW-1:0]          r_last;
    logic [CW-1:0]           r_cnt;

    logic                    w_valid;
    logic [IDW-1:0]          w_idx;

    uart_rr_picker #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_picker (
        .i_req   (REQ),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    always_ff @(posedge TX_CLK) begin
        if (TX_RST) begin
            r_state    <= ARB_IDLE;
            r_ack      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= ~START_LEVEL;
            r_busy     <= 1'b0;
            r_grant    <= '0;
            r_last     <= IDW'(N_REQ - 1);
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_valid) begin
                        r_state    <= ARB_START;
                        r_ack      <= N_REQ'(1) << w_idx;
                        r_tx_data  <= REQ_DATA[w_idx*DATA_WIDTH +: DATA_WIDTH];
                        r_tx_start <= START_LEVEL;
                        r_busy     <= 1'b1;
                        r_grant    <= w_idx;
                        r_last     <= w_idx;
                    end
                end
                ARB_START: begin
                    r_state    <= ARB_WAIT;
                    r_ack      <= '0;
                    r_tx_start <= ~START_LEVEL;
                    r_cnt      <= '0;
                end
                ARB_WAIT: begin
                    // Terminal count FRAME_CYCLES-2 gives FRAME_CYCLES-1 WAIT cycles.
                    if (r_cnt == CNT_TC) begin
                        r_state <= ARB_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign ACK        = r_ack;
    assign TX_DATA_IN = r_tx_data;
    assign TX_START   = r_tx_start;
    assign BUSY       = r_busy;
    assign GRANT_ID   = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: N_REQ=4, FRAME_CYCLES=8, START_LEVEL=0.
module tb_uart_tx_arbiter;

    localparam int   N   = 4;
    localparam int   DW  = 8;
    localparam int   FC  = 8;
    localparam logic SL  = 1'b0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    ack;
    logic [DW-1:0]   tx_data;
    logic            tx_start;
    logic            busy;
    logic [1:0]      grant_id;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .DATA_WIDTH   (DW),
        .FRAME_CYCLES (FC),
        .START_LEVEL  (SL)
    ) dut (
        .TX_CLK     (clk),
        .TX_RST     (rst),
        .REQ        (req),
        .REQ_DATA   (req_data),
        .ACK        (ack),
        .TX_DATA_IN (tx_data),
        .TX_START   (tx_start),
        .BUSY       (busy),
        .GRANT_ID   (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [7:0]  data;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_ack = 0;
    int   cyc = 0;
    int   last_ack_cyc = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(string nm, int act, int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    // Monitor: every ACK pulse is matched against the oldest expected grant.
    always @(negedge clk) begin
        exp_t e;
        if (ack != '0) begin
            n_ack++;
            if (sb.size() == 0) begin
                chk("unexpected_ack", int'(ack), 0);
            end else begin
                e = sb.pop_front();
                chk("ack_onehot", $countones(ack), 1);
                chk("ack_vec", int'(ack), 1 << e.id);
                chk("grant_id", int'(grant_id), e.id);
                chk("tx_data", int'(tx_data), int'(e.data));
                chk("tx_start_active", int'(tx_start), int'(SL));
                chk("busy_in_start", int'(busy), 1);
                if (e.gap != 0) chk("frame_period", cyc - last_ack_cyc, e.gap);
            end
            last_ack_cyc = cyc;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(int id, logic [7:0] d, int gap);
        exp_t e;
        e.id = id; e.data = d; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic set_byte(int k, logic [7:0] b);
        req_data[k*DW +: DW] = b;
    endtask

    task automatic wait_acks(int target, string nm);
        int b = 0;
        while (n_ack < target && b < 80) begin
            tick(1);
            b++;
        end
        chk({nm, "_ack_count"}, n_ack, target);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int cnt;

        // Reset values
        tick(2);
        @(negedge clk);
        chk("rst_ack", int'(ack), 0);
        chk("rst_tx_start", int'(tx_start), 1);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant", int'(grant_id), 0);
        tick(1);
        rst = 1'b0;

        // Single request from requester 1
        base = n_ack;
        set_byte(1, 8'hA5);
        push(1, 8'hA5, 0);
        req = 4'b0010;
        wait_acks(base + 1, "single");
        req = '0;
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cnt == 1) chk("tx_start_idle_in_wait", int'(tx_start), 1);
            if (busy) cnt++;
            else break;
        end
        chk("busy_cycles", cnt, FC);
        chk("data_held_after_frame", int'(tx_data), 8'hA5);

        // All requesting after reset: 0,1,2,3,0 with FC+1 spacing
        do_reset();
        base = n_ack;
        set_byte(0, 8'h10); set_byte(1, 8'h21); set_byte(2, 8'h32); set_byte(3, 8'h43);
        push(0, 8'h10, 0);
        push(1, 8'h21, FC + 1);
        push(2, 8'h32, FC + 1);
        push(3, 8'h43, FC + 1);
        push(0, 8'h10, FC + 1);
        req = 4'b1111;
        wait_acks(base + 5, "all_req");
        req = '0;
        tick(FC + 2);

        // Post-reset priority: 1001 grants 0 then 3
        do_reset();
        base = n_ack;
        set_byte(0, 8'h5A); set_byte(3, 8'hC3);
        push(0, 8'h5A, 0);
        push(3, 8'hC3, FC + 1);
        req = 4'b1001;
        wait_acks(base + 2, "post_reset");
        req = '0;
        tick(FC + 2);

        // REQ[2] pulsed during WAIT then withdrawn: must be ignored
        base = n_ack;
        set_byte(0, 8'h77);
        push(0, 8'h77, 0);
        req = 4'b0001;
        wait_acks(base + 1, "wait_ignore");
        req = '0;
        tick(2);
        set_byte(2, 8'h99);
        req[2] = 1'b1;
        tick(3);
        req[2] = 1'b0;
        tick(12);
        chk("no_ack_from_wait_pulse", n_ack, base + 1);
        chk("data_unchanged", int'(tx_data), 8'h77);
        chk("idle_after_ignore", int'(busy), 0);

        // Reset in WAIT cycle 4, then a normal grant to 2
        base = n_ack;
        set_byte(1, 8'hB4);
        push(1, 8'hB4, 0);
        req = 4'b0010;
        wait_acks(base + 1, "midframe");
        req = '0;
        tick(3);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_tx_start", int'(tx_start), 1);
        chk("midrst_tx_data", int'(tx_data), 0);
        chk("midrst_grant", int'(grant_id), 0);
        chk("midrst_ack", int'(ack), 0);
        rst = 1'b0;
        base = n_ack;
        set_byte(2, 8'hE7);
        push(2, 8'hE7, 0);
        req = 4'b0100;
        wait_acks(base + 1, "after_midrst");
        req = '0;
        tick(FC + 4);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `tx_top` UART transmitter between `N_REQ` byte producers. It captures the winning requester's byte and drives `tx_top`'s `DATA_IN` and `TX_START`. It then holds the transmitter for a fixed frame time before granting the next requester. It sits directly in front of `tx_top` and is the only block allowed to drive that transmitter.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` from `uart_params.vh`: byte width.
- `FRAME_CYCLES`, default 160: TX_CLK cycles one `tx_top` frame occupies (start + data + stop bits); must be ≥ 2.
- `START_LEVEL`, default 0: level of `TX_START` that launches a frame in `tx_top`. The idle level is the inverse.
- `TX_CLK` input, 1 bit: clock, shared with `tx_top`. One clock domain.
- `TX_RST` input, 1 bit: reset, synchronous and active-high.
- `REQ` input, `N_REQ` bits: per-requester request level.
- `REQ_DATA` input, `N_REQ*DATA_WIDTH` bits: requester k's byte is in bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `ACK` output, `N_REQ` bits: one-cycle pulse to the requester whose byte was captured.
- `TX_DATA_IN` output, `DATA_WIDTH` bits: connects to `tx_top.DATA_IN`.
- `TX_START` output, 1 bit: connects to `tx_top.TX_START`.
- `BUSY` output, 1 bit: high while a frame is owned (states START and WAIT).
- `GRANT_ID` output, `$clog2(N_REQ)` bits: index of the current or last granted requester.

## Operation
- FSM states:
  - IDLE: evaluate `REQ`. If any bit is set, pick the winner k and go to START. Otherwise stay in IDLE.
  - START: one cycle. Drive `TX_START = START_LEVEL`, pulse `ACK[k]`, and register `TX_DATA_IN` from the byte captured at the IDLE→START edge. Go to WAIT.
  - WAIT: count `FRAME_CYCLES-1` cycles. `TX_START` is at its idle level and `TX_DATA_IN` is held. Go to IDLE when the counter reaches terminal count.
- Round-robin order:
  - The search starts at `last+1` (mod `N_REQ`) and takes the first set `REQ` bit.
  - `last` updates to k on entry to START.
  - The reset value of `last` is `N_REQ-1`, so requester 0 has priority after reset.
- Requester rules:
  - Hold `REQ[k]` and `REQ_DATA[k]` stable until `ACK[k]`.
  - `REQ[k]` still high in the first IDLE cycle after the frame is a new request.
  - Dropping `REQ[k]` before the grant withdraws the request without error.
- `REQ` changes during START or WAIT are ignored. Only IDLE samples `REQ`.
- Simultaneous requests: exactly one `ACK` per frame, never two bits set.
- Counter: `$clog2(FRAME_CYCLES)` bits, cleared on entry to WAIT, no wrap beyond terminal count.
- Reset values, all outputs:
  - state IDLE
  - `ACK` = 0
  - `TX_START` = `~START_LEVEL`
  - `TX_DATA_IN` = 0
  - `BUSY` = 0
  - `GRANT_ID` = 0
  - `last` = `N_REQ-1`
  - counter = 0
- Reset mid-frame (START or WAIT): all outputs return to the reset values on the next edge and no `ACK` is reissued. The in-flight `tx_top` frame is not protected; the requester must re-request.

## Timing
- `REQ[k]` is high in IDLE at edge t. At t+1 the block is in START: `TX_START` active, `ACK[k]`=1, `GRANT_ID`=k, `BUSY`=1.
- START plus WAIT last exactly `FRAME_CYCLES` cycles.
- The block is back in IDLE at t+1+`FRAME_CYCLES`, and the next START is at the earliest 1 cycle later.
- Back-to-back frame period is therefore `FRAME_CYCLES+1` cycles.
- `ACK` is high only in START. `BUSY` deasserts in the IDLE cycle.
- All outputs are registered. There is no combinational path from `REQ` to any output.

## Structure
- `uart_params.vh` gains:
  - `` `FRAME_CYCLES `` default
  - 2-bit state encodings `` `ARB_IDLE ``=0, `` `ARB_START ``=1, `` `ARB_WAIT ``=2
- Sub-module `uart_rr_picker`: combinational. Inputs are `REQ` and `last`. Outputs are `valid` and `idx` (the rotating priority search).
- `uart_tx_arbiter` holds the FSM, counter, capture registers, and the instance of `uart_rr_picker`.

## Test plan
- Single request, `N_REQ`=4, `FRAME_CYCLES`=8:
  - Stimulus: `REQ`=0010, byte 0xA5.
  - Required: at the next edge `ACK`=0010, `TX_START`=0, `TX_DATA_IN`=0xA5, `GRANT_ID`=1.
  - Required: `BUSY` is high for 8 cycles, then IDLE.
- All requesting, `REQ`=1111 held with re-request after each `ACK`:
  - Required grant order: 0,1,2,3,0.
  - Required: each START is 9 cycles after the previous one.
- Post-reset priority:
  - Stimulus: `REQ`=1001 immediately after reset.
  - Required: grant 0 first, then 3.
- Ignored during WAIT and withdrawal:
  - Stimulus: `REQ[2]` pulses for 3 cycles during WAIT, then drops.
  - Required: no `ACK[2]`, `TX_DATA_IN` unchanged.
- Reset mid-frame:
  - Stimulus: `TX_RST`=1 in WAIT cycle 4.
  - Required: at the next edge `BUSY`=0, `TX_START`=1, `TX_DATA_IN`=0, `GRANT_ID`=0, `ACK`=0.
  - Required: a subsequent `REQ`=0100 grants 2 normally.
